// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, architectural register indices and ABI reset values.
// Used by the register file, control unit and writeback mux.
package mips_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_GP   = 28;
   localparam int unsigned REG_SP   = 29;
   localparam int unsigned REG_RA   = 31;

   localparam logic [DATA_W-1:0] GP_INIT = 32'h1000_8000;
   localparam logic [DATA_W-1:0] SP_INIT = 32'h7FFF_EFFC;

endpackage : mips_pkg

// File: rtl/register_file.sv
// MIPS integer register file: 2 combinational read ports, 1 synchronous write port, $zero hardwired.
// Optional same-cycle write-to-read bypass when REGFILE_WRITE_BYPASS_EN is defined.
module register_file #(
   parameter int unsigned          DATA_W  = mips_pkg::DATA_W,
   parameter int unsigned          ADDR_W  = mips_pkg::ADDR_W,
   parameter logic [DATA_W-1:0]    GP_INIT = DATA_W'(mips_pkg::GP_INIT),
   parameter logic [DATA_W-1:0]    SP_INIT = DATA_W'(mips_pkg::SP_INIT)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);
   import mips_pkg::REG_ZERO;
   import mips_pkg::REG_GP;
   import mips_pkg::REG_SP;

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);
   localparam logic [ADDR_W-1:0] IDX_GP   = ADDR_W'(REG_GP);
   localparam logic [ADDR_W-1:0] IDX_SP   = ADDR_W'(REG_SP);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_en;

   assign wr_en = RegWrite && (write_reg != IDX_ZERO);

   // Storage: reset loads ABI values and wins over a coincident write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         regs[IDX_GP] <= GP_INIT;
         regs[IDX_SP] <= SP_INIT;
      end else if (wr_en) begin
         regs[write_reg] <= write_data;
      end
   end

   // Read muxes; index 0 is forced to zero independent of array contents.
   always_comb begin
      read_data1 = (read_reg1 == IDX_ZERO) ? '0 : regs[read_reg1];
      read_data2 = (read_reg2 == IDX_ZERO) ? '0 : regs[read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_en && !reset && (write_reg == read_reg1)) begin
         read_data1 = write_data;
      end
      if (wr_en && !reset && (write_reg == read_reg2)) begin
         read_data2 = write_data;
      end
`endif
   end

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// against an array-based model of the architectural register state.
module tb_register_file;

   localparam logic [31:0] GP_VAL = 32'h1000_8000;
   localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [31:0] read_data1;
   logic [31:0] read_data2;

   int checks;
   int errors;

   logic [31:0] mem [32];
   bit          model_ok;

   register_file dut (
      .clk        (clk),
      .reset      (reset),
      .RegWrite   (RegWrite),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // What a port should show right now, given stored state and the current write request.
   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (RegWrite && !reset && write_reg != 5'd0 && write_reg == idx) return write_data;
`endif
      return mem[idx];
   endfunction

   // Drive one cycle, check both ports before the edge, then advance the model across it.
   task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
      reset      = rst;
      RegWrite   = we;
      write_reg  = wr;
      write_data = wd;
      read_reg1  = r1;
      read_reg2  = r2;
      #1;
      if (model_ok) begin
         check("rd1", read_data1, model_read(r1));
         check("rd2", read_data2, model_read(r2));
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'h0;
         mem[28]  = GP_VAL;
         mem[29]  = SP_VAL;
         model_ok = 1'b1;
      end else if (we && wr != 5'd0) begin
         mem[wr] = wd;
      end
      #1;
   endtask

   // Combinational read with no write pending, compared against fixed expectations.
   task automatic look(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] e1, input logic [31:0] e2);
      reset     = 1'b0;
      RegWrite  = 1'b0;
      read_reg1 = r1;
      read_reg2 = r2;
      #1;
      check({tag, "_a"}, read_data1, e1);
      check({tag, "_b"}, read_data2, e2);
   endtask

   initial begin
      logic [4:0] wr;
      logic [4:0] r1;
      logic [4:0] r2;
      checks     = 0;
      errors     = 0;
      model_ok   = 1'b0;
      reset      = 1'b0;
      RegWrite   = 1'b0;
      read_reg1  = '0;
      read_reg2  = '0;
      write_reg  = '0;
      write_data = '0;

      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      look("rst_0_gp", 5'd0, 5'd28, 32'h0, GP_VAL);
      look("rst_sp_8", 5'd29, 5'd8, SP_VAL, 32'h0);

      step(1'b0, 1'b1, 5'd8, 32'd3, 5'd8, 5'd9);
      step(1'b0, 1'b1, 5'd9, 32'd1, 5'd8, 5'd9);
      look("sub_ops", 5'd8, 5'd9, 32'd3, 32'd1);

      step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      look("zero_wr", 5'd0, 5'd0, 32'h0, 32'h0);

      step(1'b0, 1'b0, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd8);
      look("no_we", 5'd8, 5'd8, 32'd3, 32'd3);

      step(1'b1, 1'b1, 5'd9, 32'd7, 5'd9, 5'd29);
      look("rst_prio", 5'd9, 5'd29, 32'h0, SP_VAL);

      // Same-cycle write and read of reg10.
      reset      = 1'b0;
      RegWrite   = 1'b1;
      write_reg  = 5'd10;
      write_data = 32'h55;
      read_reg1  = 5'd10;
      read_reg2  = 5'd10;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      check("same_cyc", read_data1, 32'h55);
`else
      check("same_cyc", read_data1, 32'h0);
`endif
      @(posedge clk);
      mem[10] = 32'h55;
      #1;
      look("after_wr", 5'd10, 5'd10, 32'h55, 32'h55);

      for (int n = 0; n < 400; n++) begin
         wr = 5'($urandom_range(0, 31));
         r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
         step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), wr, $urandom, r1, r2);
      end

      for (int i = 0; i < 32; i += 2) begin
         look("final", 5'(i), 5'(i + 1), mem[i], mem[i + 1]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- MIPS integer register file. Sits directly upstream of the ALU-control/ALU stage and supplies its a and b operands: read_data1 drives a, read_data2 drives b.
- Provides 32 x 32-bit registers with two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero. $gp and $sp take ABI reset values.

Parameters:
- DATA_W, 32, width of every register and data port.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- GP_INIT, 32'h10008000, reset value of register 28 ($gp).
- SP_INIT, 32'h7FFFEFFC, reset value of register 29 ($sp).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite  input  1  write enable from main control.
- read_reg1  input  ADDR_W  rs index.
- read_reg2  input  ADDR_W  rt index.
- write_reg  input  ADDR_W  destination index (rd or rt, already muxed upstream).
- write_data  input  DATA_W  value to write (ALU result or memory data, already muxed upstream).
- read_data1  output  DATA_W  contents of read_reg1; feeds ALU input a.
- read_data2  output  DATA_W  contents of read_reg2; feeds ALU input b.

Behaviour:
- Clock and reset (decided): one clock, clk; reset is synchronous and active-high.
- Reset: on the rising edge with reset=1, all registers clear to 0, except reg28=GP_INIT and reg29=SP_INIT. Reset completes in one cycle.
- Reset has priority over RegWrite in the same cycle; that write is dropped.
- Read outputs are combinational from the array, so there is no reset value of their own. After reset, read_data reflects the reset contents for the selected index. Read latency is 0 cycles.
- Write: on the rising edge with reset=0, RegWrite=1 and write_reg!=0, the register at write_reg takes write_data. Write latency is 1 cycle, visible on the read ports after the edge.
- Register 0: writes are silently ignored. Reads of index 0 always return 0, including when write_reg=0 with RegWrite=1.
- RegWrite=0: no state change, whatever write_reg and write_data hold.
- Same-index read and write in one cycle (without the optional feature): the read returns the old value until the edge.
- Both read ports may address the same register; both return the same value.
- Reset asserted mid-operation, with RegWrite=1, wipes pending state. The next cycle reads reset values.
- No X propagation: every register is defined after the first reset.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: each read port returns write_data combinationally when all of these hold: RegWrite=1, reset=0, write_reg!=0 and write_reg equals that port's read index. This gives write-before-read in the same cycle, used for the pipelined variant.
- Undefined: reads return stored contents only; behaviour is exactly as above.
- Register 0 and reset priority are identical in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W=32, ADDR_W=5.
  - Register index constants REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31.
  - GP_INIT and SP_INIT default constants.
  - These constants are shared with the control unit and the writeback mux.
- No sub-module: a single flat module with the storage array, write logic and two read muxes.

Test Plan:
- Reset, then read index 0, 28, 29 and 8 -> 0x00000000, 0x10008000, 0x7FFFEFFC, 0x00000000.
- Write 3 to reg8 and 1 to reg9 (RegWrite=1, one per cycle); read_reg1=8, read_reg2=9 -> read_data1=3, read_data2=1, the ALU operands for the SUB case.
- RegWrite=1, write_reg=0, write_data=0xFFFFFFFF; then read index 0 on both ports -> 0x00000000.
- RegWrite=0, write_reg=8, write_data=0xDEADBEEF -> reg8 still reads 3 on the next cycle.
- reset=1 and RegWrite=1 on the same edge (write_reg=9, write_data=7) -> reg9 reads 0 afterwards; reg29 reads 0x7FFFEFFC.
- Same-cycle write reg10=0x55 with read_reg1=10: undefined macro -> old value 0 before the edge and 0x55 after; defined macro -> 0x55 in the same cycle.
